// File: rtl/fx2_slave_fifo_writer.sv
// fx2_slave_fifo_writer: IFCLK sample FIFO drained into the FX2LP slave FIFO.
// Define FX2_FLUSH_TIMEOUT_EN for the idle-timeout PKTENDN short-packet commit.
module fx2_slave_fifo_writer #(
  parameter int DEPTH_LOG2 = 4,
  parameter int PKT_BYTES  = 512
) (
  input  logic                  CLK,
  input  logic                  RESET_N,
  input  logic                  ENABLE,
  input  logic                  CLEAR,
  input  logic [7:0]            IN_DATA,
  input  logic                  IN_VALID,
  input  logic                  FLAGN_FULL,
`ifdef FX2_FLUSH_TIMEOUT_EN
  input  logic [15:0]           FLUSH_TIMEOUT,
`endif
  output logic [7:0]            FD,
  output logic                  SLWRN,
  output logic                  PKTENDN,
  output logic [DEPTH_LOG2:0]   LEVEL,
  output logic                  OVERFLOW,
  output logic [15:0]           DROP_COUNT
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int LW    = DEPTH_LOG2 + 1;
  localparam int PW    = (PKT_BYTES > 1) ? $clog2(PKT_BYTES) : 1;
  localparam logic [PW-1:0] PKT_LAST = PW'(PKT_BYTES - 1);

  logic [7:0]            mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]         level_q, level_d;
  logic [7:0]            fd_q, fd_d;
  logic                  slwrn_q, slwrn_d;
  logic                  pktendn_q, pktendn_d;
  logic                  ovf_q, ovf_d;
  logic [15:0]           drop_q, drop_d;
  logic [PW-1:0]         pkt_q, pkt_d;

  logic full;
  logic empty;
  logic push;
  logic pop;
  logic drop;
  logic flush;

  assign full  = (level_q == LW'(DEPTH));
  assign empty = (level_q == '0);
  assign push  = !CLEAR && ENABLE && IN_VALID && !full;
  assign drop  = !CLEAR && ENABLE && IN_VALID && full;
  assign pop   = !CLEAR && ENABLE && FLAGN_FULL && !empty;

`ifdef FX2_FLUSH_TIMEOUT_EN
  logic [15:0] idle_q, idle_d;

  // Commit a short packet only when the bus is quiet and something is pending.
  assign flush = !CLEAR && ENABLE && FLAGN_FULL && !pop
              && (FLUSH_TIMEOUT != '0) && (pkt_q != '0)
              && (idle_q == FLUSH_TIMEOUT);

  always_comb begin
    idle_d = idle_q;
    if (CLEAR) begin
      idle_d = '0;
    end else if (push || pop || flush) begin
      idle_d = '0;
    end else if (ENABLE && idle_q != 16'hFFFF) begin
      idle_d = idle_q + 16'd1;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      idle_q <= '0;
    end else begin
      idle_q <= idle_d;
    end
  end
`else
  assign flush = 1'b0;
`endif

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    level_d   = level_q;
    fd_d      = fd_q;
    slwrn_d   = 1'b1;
    pktendn_d = 1'b1;
    ovf_d     = ovf_q;
    drop_d    = drop_q;
    pkt_d     = pkt_q;
    if (CLEAR) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
      ovf_d    = 1'b0;
      drop_d   = '0;
      pkt_d    = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(1);
        fd_d     = mem_q[rd_ptr_q];
        slwrn_d  = 1'b0;
        // FX2 auto-commits full packets, so the count just wraps.
        pkt_d    = (pkt_q == PKT_LAST) ? '0 : pkt_q + PW'(1);
      end
      if (drop) begin
        ovf_d = 1'b1;
        if (drop_q != 16'hFFFF) begin
          drop_d = drop_q + 16'd1;
        end
      end
      case ({push, pop})
        2'b10:   level_d = level_q + LW'(1);
        2'b01:   level_d = level_q - LW'(1);
        default: level_d = level_q;
      endcase
      if (flush) begin
        pktendn_d = 1'b0;
        pkt_d     = '0;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (push) begin
      mem_q[wr_ptr_q] <= IN_DATA;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      fd_q      <= '0;
      slwrn_q   <= 1'b1;
      pktendn_q <= 1'b1;
      ovf_q     <= 1'b0;
      drop_q    <= '0;
      pkt_q     <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      fd_q      <= fd_d;
      slwrn_q   <= slwrn_d;
      pktendn_q <= pktendn_d;
      ovf_q     <= ovf_d;
      drop_q    <= drop_d;
      pkt_q     <= pkt_d;
    end
  end

  assign FD         = fd_q;
  assign SLWRN      = slwrn_q;
  assign PKTENDN    = pktendn_q;
  assign LEVEL      = level_q;
  assign OVERFLOW   = ovf_q;
  assign DROP_COUNT = drop_q;

endmodule

// File: tb/tb_fx2_slave_fifo_writer.sv
// Bench for fx2_slave_fifo_writer: directed scenarios plus random traffic
// against a queue-based reference model.
module tb_fx2_slave_fifo_writer;

  localparam int PKT = 512;

  logic        CLK = 1'b0;
  logic        RESET_N;
  logic        ENABLE;
  logic        CLEAR;
  logic [7:0]  IN_DATA;
  logic        IN_VALID;
  logic        FLAGN_FULL;
  logic [15:0] tmo;
  logic [7:0]  FD;
  logic        SLWRN;
  logic        PKTENDN;
  logic [4:0]  LEVEL;
  logic        OVERFLOW;
  logic [15:0] DROP_COUNT;

  int n_checks = 0;
  int n_err    = 0;

  // reference model state
  logic [7:0] m_q[$];
  logic [7:0] m_fd;
  logic       m_slwrn;
  logic       m_pktendn;
  logic       m_ovf;
  int         m_drops;
  int         m_pkt;
  int         m_idle;

  fx2_slave_fifo_writer #(.DEPTH_LOG2(4), .PKT_BYTES(PKT)) dut (
    .CLK(CLK),
    .RESET_N(RESET_N),
    .ENABLE(ENABLE),
    .CLEAR(CLEAR),
    .IN_DATA(IN_DATA),
    .IN_VALID(IN_VALID),
    .FLAGN_FULL(FLAGN_FULL),
`ifdef FX2_FLUSH_TIMEOUT_EN
    .FLUSH_TIMEOUT(tmo),
`endif
    .FD(FD),
    .SLWRN(SLWRN),
    .PKTENDN(PKTENDN),
    .LEVEL(LEVEL),
    .OVERFLOW(OVERFLOW),
    .DROP_COUNT(DROP_COUNT)
  );

  always #5 CLK = ~CLK;

  task automatic model_reset();
    m_q.delete();
    m_fd = 8'h00; m_slwrn = 1'b1; m_pktendn = 1'b1;
    m_ovf = 1'b0; m_drops = 0; m_pkt = 0; m_idle = 0;
  endtask

  // Drive one cycle of inputs, advance the model, land 1ns after the edge.
  task automatic tick(input logic clr, input logic en, input logic v,
                      input logic [7:0] d, input logic ff);
    int lvl;
    bit pop, push, flush;
    CLEAR = clr; ENABLE = en; IN_VALID = v; IN_DATA = d; FLAGN_FULL = ff;
    m_slwrn = 1'b1; m_pktendn = 1'b1;
    if (clr) begin
      m_q.delete(); m_ovf = 1'b0; m_drops = 0; m_pkt = 0; m_idle = 0;
    end else if (en) begin
      lvl = m_q.size();
      pop = ff && lvl != 0;
      push = v && lvl < 16;
      flush = 1'b0;
`ifdef FX2_FLUSH_TIMEOUT_EN
      flush = !pop && ff && tmo != 0 && m_pkt != 0 && m_idle == int'(tmo);
`endif
      if (pop) begin
        m_fd = m_q.pop_front(); m_slwrn = 1'b0; m_pkt = (m_pkt + 1) % PKT;
      end
      if (v && !push) begin
        m_ovf = 1'b1;
        if (m_drops < 65535) m_drops++;
      end
      if (push) m_q.push_back(d);
      if (flush) begin m_pktendn = 1'b0; m_pkt = 0; end
      if (push || pop || flush) m_idle = 0;
      else if (m_idle < 65535) m_idle++;
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RESET_N = 1'b0; ENABLE = 0; CLEAR = 0; IN_VALID = 0;
    IN_DATA = 0; FLAGN_FULL = 0; tmo = 0;
    model_reset();
    #12;
    n_checks++;
    if (FD !== 8'h00 || SLWRN !== 1'b1 || PKTENDN !== 1'b1 || LEVEL !== 5'd0
        || OVERFLOW !== 1'b0 || DROP_COUNT !== 16'd0) begin
      n_err++;
      $display("FAIL reset_init: FD=%h SLWRN=%b PKTENDN=%b LEVEL=%0d OVF=%b DROP=%0d, want 00 1 1 0 0 0",
               FD, SLWRN, PKTENDN, LEVEL, OVERFLOW, DROP_COUNT);
    end
    RESET_N = 1'b1;
    for (int i = 0; i < 6; i++) tick(0, 1, 1, 8'(8'h40 + i), 0);
    tick(0, 1, 0, 8'h00, 1);
    n_checks++;
    if (LEVEL !== 5'd5 || SLWRN !== 1'b0 || FD !== 8'h40) begin
      n_err++;
      $display("FAIL reset_setup: LEVEL=%0d SLWRN=%b FD=%h, want 5 0 40", LEVEL, SLWRN, FD);
    end
    #2;
    RESET_N = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if (SLWRN !== 1'b1 || FD !== 8'h00 || LEVEL !== 5'd0 || PKTENDN !== 1'b1) begin
      n_err++;
      $display("FAIL reset_async: SLWRN=%b FD=%h LEVEL=%0d PKTENDN=%b, want 1 00 0 1",
               SLWRN, FD, LEVEL, PKTENDN);
    end
    #2;
    RESET_N = 1'b1;
  endtask

  task automatic test_stream();
    int lows = 0, exp = 1, bad = 0, maxlvl = 0;
    tick(1, 1, 0, 8'h00, 1);
    for (int i = 0; i < 40; i++) begin
      if (i < 32) tick(0, 1, 1, 8'(i + 1), 1);
      else tick(0, 1, 0, 8'h00, 1);
      if (i == 0) begin
        n_checks++;
        if (SLWRN !== 1'b1) begin
          n_err++;
          $display("FAIL stream_latency: SLWRN=%b after first push, want 1", SLWRN);
        end
      end
      if (i == 1) begin
        n_checks++;
        if (SLWRN !== 1'b0 || FD !== 8'h01) begin
          n_err++;
          $display("FAIL stream_first: SLWRN=%b FD=%h, want 0 01", SLWRN, FD);
        end
      end
      if (int'(LEVEL) > maxlvl) maxlvl = int'(LEVEL);
      if (SLWRN === 1'b0) begin
        if (FD !== 8'(exp)) bad++;
        exp++; lows++;
      end
    end
    n_checks++;
    if (lows != 32 || bad != 0 || maxlvl > 1) begin
      n_err++;
      $display("FAIL stream: lows=%0d order_errs=%0d maxlvl=%0d, want 32 0 <=1",
               lows, bad, maxlvl);
    end
  endtask

  task automatic test_overflow();
    int exp = 1, bad = 0;
    tick(1, 1, 0, 8'h00, 0);
    for (int i = 1; i <= 20; i++) tick(0, 1, 1, 8'(i), 0);
    n_checks++;
    if (LEVEL !== 5'd16 || DROP_COUNT !== 16'd4 || OVERFLOW !== 1'b1) begin
      n_err++;
      $display("FAIL overflow: LEVEL=%0d DROP=%0d OVF=%b, want 16 4 1",
               LEVEL, DROP_COUNT, OVERFLOW);
    end
    for (int i = 0; i < 20; i++) begin
      tick(0, 1, 0, 8'h00, 1);
      if (SLWRN === 1'b0) begin
        if (FD !== 8'(exp)) bad++;
        exp++;
      end
    end
    n_checks++;
    if (exp != 17 || bad != 0 || LEVEL !== 5'd0) begin
      n_err++;
      $display("FAIL overflow_drain: popped=%0d order_errs=%0d LEVEL=%0d, want 16 0 0",
               exp - 1, bad, LEVEL);
    end
    tick(1, 1, 1, 8'hEE, 1);
    n_checks++;
    if (OVERFLOW !== 1'b0 || DROP_COUNT !== 16'd0 || LEVEL !== 5'd0 || SLWRN !== 1'b1) begin
      n_err++;
      $display("FAIL clear: OVF=%b DROP=%0d LEVEL=%0d SLWRN=%b, want 0 0 0 1",
               OVERFLOW, DROP_COUNT, LEVEL, SLWRN);
    end
  endtask

  task automatic test_full_pop();
    for (int i = 0; i < 16; i++) tick(0, 1, 1, 8'(8'hA0 + i), 0);
    tick(0, 1, 1, 8'h55, 1);
    n_checks++;
    if (DROP_COUNT !== 16'd1 || LEVEL !== 5'd15 || SLWRN !== 1'b0 || FD !== 8'hA0) begin
      n_err++;
      $display("FAIL full_pop: DROP=%0d LEVEL=%0d SLWRN=%b FD=%h, want 1 15 0 a0",
               DROP_COUNT, LEVEL, SLWRN, FD);
    end
  endtask

  task automatic test_enable();
    int lows = 0;
    tick(1, 1, 0, 8'h00, 0);
    for (int i = 0; i < 4; i++) tick(0, 1, 1, 8'(8'h10 + i), 0);
    for (int i = 0; i < 5; i++) begin
      tick(0, 0, 1, 8'hFF, 1);
      if (SLWRN === 1'b0) lows++;
    end
    n_checks++;
    if (lows != 0 || LEVEL !== 5'd4 || DROP_COUNT !== 16'd0) begin
      n_err++;
      $display("FAIL enable_freeze: lows=%0d LEVEL=%0d DROP=%0d, want 0 4 0",
               lows, LEVEL, DROP_COUNT);
    end
    tick(0, 1, 0, 8'h00, 1);
    n_checks++;
    if (SLWRN !== 1'b0 || FD !== 8'h10) begin
      n_err++;
      $display("FAIL enable_resume: SLWRN=%b FD=%h, want 0 10", SLWRN, FD);
    end
  endtask

  task automatic test_flush();
    int last_sl = -1, pe_at = -1, pe_n = 0;
    tmo = 16'd10;
    tick(1, 1, 0, 8'h00, 1);
    for (int i = 0; i < 40; i++) begin
      if (i < 3) tick(0, 1, 1, 8'(i + 1), 1);
      else tick(0, 1, 0, 8'h00, 1);
      if (SLWRN === 1'b0) last_sl = i;
      if (PKTENDN === 1'b0) begin pe_at = i; pe_n++; end
    end
`ifdef FX2_FLUSH_TIMEOUT_EN
    n_checks++;
    if (pe_n != 1 || pe_at != last_sl + 11) begin
      n_err++;
      $display("FAIL flush_timeout: pktend_count=%0d at=%0d last_slwr=%0d, want 1 at last+11",
               pe_n, pe_at, last_sl);
    end
`else
    n_checks++;
    if (pe_n != 0) begin
      n_err++;
      $display("FAIL pktend_const: pktend_count=%0d, want 0", pe_n);
    end
`endif
    tmo = 16'd0;
    pe_n = 0;
    for (int i = 0; i < 40; i++) begin
      if (i < 3) tick(0, 1, 1, 8'(i + 1), 1);
      else tick(0, 1, 0, 8'h00, 1);
      if (PKTENDN === 1'b0) pe_n++;
    end
    n_checks++;
    if (pe_n != 0) begin
      n_err++;
      $display("FAIL flush_disabled: pktend_count=%0d, want 0", pe_n);
    end
  endtask

  task automatic test_packet_wrap();
    int lows = 0, bad = 0, pe_n = 0;
    tmo = 16'd10;
    tick(1, 1, 0, 8'h00, 1);
    for (int i = 0; i < 560; i++) begin
      if (i < PKT) tick(0, 1, 1, 8'(i), 1);
      else tick(0, 1, 0, 8'h00, 1);
      if (SLWRN === 1'b0) begin
        if (FD !== 8'(lows)) bad++;
        lows++;
      end
      if (PKTENDN === 1'b0) pe_n++;
    end
    n_checks++;
    if (lows != PKT || bad != 0 || pe_n != 0) begin
      n_err++;
      $display("FAIL packet_wrap: writes=%0d order_errs=%0d pktend=%0d, want 512 0 0",
               lows, bad, pe_n);
    end
  endtask

  task automatic test_random();
    int bad = 0, both = 0;
    tmo = 16'(3 + $urandom_range(0, 4));
    tick(1, 1, 0, 8'h00, 1);
    for (int i = 0; i < 2000; i++) begin
      tick($urandom_range(0, 199) == 0, $urandom_range(0, 15) != 0,
           $urandom_range(0, 99) < 45, 8'($urandom), $urandom_range(0, 99) < 40);
      if (FD !== m_fd || SLWRN !== m_slwrn || PKTENDN !== m_pktendn
          || LEVEL !== 5'(m_q.size()) || OVERFLOW !== m_ovf
          || DROP_COUNT !== 16'(m_drops)) begin
        if (bad < 5)
          $display("FAIL random cyc %0d: FD=%h/%h SLWRN=%b/%b PKTENDN=%b/%b LEVEL=%0d/%0d OVF=%b/%b DROP=%0d/%0d (got/want)",
                   i, FD, m_fd, SLWRN, m_slwrn, PKTENDN, m_pktendn, LEVEL,
                   m_q.size(), OVERFLOW, m_ovf, DROP_COUNT, m_drops);
        bad++;
      end
      if (SLWRN === 1'b0 && PKTENDN === 1'b0) both++;
    end
    n_checks++;
    if (bad != 0) n_err++;
    n_checks++;
    if (both != 0) begin
      n_err++;
      $display("FAIL strobe_overlap: cycles=%0d, want 0", both);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_overflow();
    test_full_pop();
    test_enable();
    test_flush();
    test_packet_wrap();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/fx2_slave_fifo_writer.md
Name: fx2_slave_fifo_writer

Overview:
- Buffers the 8-bit sample stream produced on IFCLK (ADC capture or decimator output) in a small FIFO.
- Drains the FIFO into the FX2LP slave FIFO through FD/SLWRN, honouring the FX2 full flag.
- Counts and reports samples dropped on overflow.
- Optionally commits short packets with PKTENDN after an idle timeout, so low-rate streams reach the host without waiting for a full packet.

Parameters:
- DEPTH_LOG2, 4: FIFO depth is 2^DEPTH_LOG2 bytes (16).
- PKT_BYTES, 512: FX2 endpoint packet size in bytes; the packet byte counter wraps at this value.

Ports:
- CLK  in  1  IFCLK domain clock (48 MHz); all logic on the rising edge.
- RESET_N  in  1  asynchronous active-low reset.
- ENABLE  in  1  1 = accept and drain samples; 0 = freeze pushes and pops, FIFO contents retained.
- CLEAR  in  1  synchronous flush: empties FIFO, zeroes counters and flags.
- IN_DATA  in  8  sample byte.
- IN_VALID  in  1  IN_DATA valid this cycle; there is no backpressure.
- FLAGN_FULL  in  1  FX2 full flag, active low (1 = space available); used combinationally.
- FD  out  8  slave FIFO data, registered.
- SLWRN  out  1  slave FIFO write strobe, active low, registered.
- PKTENDN  out  1  packet commit strobe, active low, registered.
- LEVEL  out  DEPTH_LOG2+1  current FIFO occupancy.
- OVERFLOW  out  1  sticky: at least one sample dropped since reset or CLEAR.
- DROP_COUNT  out  16  number of dropped samples, saturating at 0xFFFF.
- FLUSH_TIMEOUT  in  16  idle cycles before a short packet is committed; present only with FX2_FLUSH_TIMEOUT_EN.

Behaviour:
- Reset (RESET_N low, asynchronous) sets FD=0x00, SLWRN=1, PKTENDN=1, LEVEL=0, OVERFLOW=0, DROP_COUNT=0, and clears the packet counter and idle counter.
- Priority order is CLEAR, then ENABLE, then push/pop.
- CLEAR=1 at an edge: LEVEL=0, OVERFLOW=0, DROP_COUNT=0, packet counter=0, idle counter=0, SLWRN=1, PKTENDN=1, FD holds. Any IN_VALID in that cycle is discarded and not counted as a drop.
- Push occurs when ENABLE & IN_VALID & (LEVEL < 2^DEPTH_LOG2), using LEVEL before this cycle's pop.
- A push attempted while full is a drop: OVERFLOW<=1 and DROP_COUNT increments, saturating at 0xFFFF. The drop occurs even if a pop happens in the same cycle.
- Pop occurs when ENABLE & FLAGN_FULL & (LEVEL != 0), using LEVEL before this cycle's push. There is no bypass.
- On a pop edge: FD<=head byte, SLWRN<=0.
- When no pop occurs: SLWRN<=1 and FD holds its last value.
- Push and pop in the same cycle leave LEVEL unchanged.
- Latency: a byte pushed at edge N is popped at the earliest at edge N+1, so SLWRN is low after edge N+1.
- Sustained throughput is 1 byte per cycle while FLAGN_FULL=1.
- Data order is strict FIFO; the read/write pointers wrap modulo 2^DEPTH_LOG2.
- Packet counter: +1 per pop; on reaching PKT_BYTES-1 and popping, it wraps to 0, because the FX2 auto-commits full packets.
- ENABLE=0: SLWRN<=1 and PKTENDN<=1 next edge; counters hold.
- FLAGN_FULL dropping to 0 stops pops that same cycle; the data stays queued.

Optional Feature:
- Macro: FX2_FLUSH_TIMEOUT_EN.
- With the macro, the FLUSH_TIMEOUT port exists and an idle counter is built:
  - The idle counter increments each cycle with ENABLE=1 and no pop and no push.
  - It resets to 0 on any push or pop.
  - When it equals FLUSH_TIMEOUT, FLUSH_TIMEOUT != 0, packet counter != 0 and FLAGN_FULL=1: PKTENDN<=0 for exactly one cycle, the packet counter resets to 0, and the idle counter resets to 0.
  - PKTENDN and SLWRN are never low in the same cycle.
  - FLUSH_TIMEOUT=0 disables flushing.
- Without the macro: no FLUSH_TIMEOUT port, no idle counter, and PKTENDN is constant 1.

Test Plan:
- Reset mid-stream, with LEVEL=5 and SLWRN low → outputs immediately show SLWRN=1, FD=0x00, LEVEL=0, PKTENDN=1.
- ENABLE=1, FLAGN_FULL=1, push bytes 0x01..0x20 on consecutive cycles → FD shows 0x01..0x20 in order, SLWRN low for exactly 32 cycles, first SLWRN low one edge after the first push, LEVEL never exceeds 1.
- FLAGN_FULL=0, push 20 bytes → LEVEL=16, DROP_COUNT=4, OVERFLOW=1. Then set FLAGN_FULL=1 → bytes 1..16 drain in order. Then CLEAR → OVERFLOW=0, DROP_COUNT=0.
- Full FIFO with IN_VALID and pop in the same cycle → byte dropped, DROP_COUNT+1, LEVEL goes 16→15.
- With macro, FLUSH_TIMEOUT=10, push 3 bytes then idle → PKTENDN low for one cycle exactly 10 idle cycles after the last SLWRN pulse, no further PKTENDN. With FLUSH_TIMEOUT=0 → PKTENDN never asserts.
- Push exactly 512 bytes, then idle with the macro enabled → packet counter wraps to 0 and no PKTENDN is generated.
